intersection_controller: RTL and testbench

INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

---
 rtl/traffic_pkg.sv | 73 +++++++
 rtl/phase_timer.sv | 60 ++++++
 rtl/intersection_controller.sv | 154 +++++++++++++++
 tb/tb_intersection_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types, default timings and lamp decoding for the intersection controller.
package traffic_pkg;

  localparam int DEF_N_PHASES     = 2;
  localparam int DEF_T_IDLE       = 6;
  localparam int DEF_T_ALL_RED    = 2;
  localparam int DEF_T_RED_YELLOW = 3;
  localparam int DEF_T_GREEN      = 20;
  localparam int DEF_T_MIN_GREEN  = 5;
  localparam int DEF_T_COUNTDOWN  = 9;
  localparam int DEF_T_GREEN_BLINK = 6;
  localparam int DEF_T_YELLOW     = 3;

  // Width of the per-state cycle timer and of the countdown display value.
  localparam int TIMER_W = 8;
  localparam int CD_W    = 4;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    ALL_RED     = 3'd1,
    RED_YELLOW  = 3'd2,
    GREEN       = 3'd3,
    GREEN_BLINK = 3'd4,
    YELLOW      = 3'd5
  } state_e;

  // All lamps belonging to one phase / crossing.
  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
    logic ped_red;
    logic ped_green;
  } lamp_vec_t;

  // Lamp pattern of one phase, from registered state only.
  function automatic lamp_vec_t decode_lamps(input state_e state, input logic is_active,
                                             input logic timer_odd, input logic blink);
    lamp_vec_t l;
    l = '0;
    case (state)
      IDLE: l.yellow = blink;
      ALL_RED: begin
        l.red     = 1'b1;
        l.ped_red = 1'b1;
      end
      RED_YELLOW: begin
        l.red     = 1'b1;
        l.yellow  = is_active;
        l.ped_red = 1'b1;
      end
      GREEN: begin
        l.red       = ~is_active;
        l.green     = is_active;
        l.ped_red   = ~is_active;
        l.ped_green = is_active;
      end
      GREEN_BLINK: begin
        l.red     = ~is_active;
        l.green   = is_active & ~timer_odd;
        l.ped_red = 1'b1;
      end
      YELLOW: begin
        l.red     = ~is_active;
        l.yellow  = is_active;
        l.ped_red = 1'b1;
      end
      default: l = '0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-state cycle timer plus the loadable countdown shown on the display.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int CD_LEN = DEF_T_COUNTDOWN
) (
  input  logic               clk_1Hz,
  input  logic               rst_n,
  input  logic               timer_clear,
  input  logic               cd_load,
  input  logic               cd_abort,
  output logic [TIMER_W-1:0] timer,
  output logic [CD_W-1:0]    countdown,
  output logic               countdown_valid,
  output logic               cd_done
);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               cd_valid_q, cd_valid_d;

  // Timer restarts from zero whenever the controller changes state or is held idle.
  always_comb begin
    timer_d = timer_clear ? '0 : timer_q + TIMER_W'(1);
  end

  // Countdown: abort wins, then load, then count down to zero and hold there.
  always_comb begin
    cd_d       = cd_q;
    cd_valid_d = cd_valid_q;
    if (cd_abort) begin
      cd_d       = '0;
      cd_valid_d = 1'b0;
    end else if (cd_load) begin
      cd_d       = CD_W'(CD_LEN - 1);
      cd_valid_d = 1'b1;
    end else if (cd_valid_q && (cd_q != '0)) begin
      cd_d = cd_q - CD_W'(1);
    end
  end

  // Timer and countdown registers.
  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      timer_q    <= '0;
      cd_q       <= '0;
      cd_valid_q <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      cd_q       <= cd_d;
      cd_valid_q <= cd_valid_d;
    end
  end

  assign timer           = timer_q;
  assign countdown       = cd_q;
  assign countdown_valid = cd_valid_q;
  assign cd_done         = cd_valid_q && (cd_q == '0);

endmodule

// File: rtl/intersection_controller.sv
// Round-robin traffic light controller with pedestrian-shortened green.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int N_PHASES      = DEF_N_PHASES,
  parameter int T_IDLE        = DEF_T_IDLE,
  parameter int T_ALL_RED     = DEF_T_ALL_RED,
  parameter int T_RED_YELLOW  = DEF_T_RED_YELLOW,
  parameter int T_GREEN       = DEF_T_GREEN,
  parameter int T_MIN_GREEN   = DEF_T_MIN_GREEN,
  parameter int T_COUNTDOWN   = DEF_T_COUNTDOWN,
  parameter int T_GREEN_BLINK = DEF_T_GREEN_BLINK,
  parameter int T_YELLOW      = DEF_T_YELLOW
) (
  input  logic                clk_1Hz,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [N_PHASES-1:0] ped_req,
  output logic [N_PHASES-1:0] red,
  output logic [N_PHASES-1:0] yellow,
  output logic [N_PHASES-1:0] green,
  output logic [N_PHASES-1:0] ped_red,
  output logic [N_PHASES-1:0] ped_green,
  output logic [1:0]          active_phase,
  output logic [3:0]          countdown,
  output logic                countdown_valid
);

  state_e              state_q, state_d;
  logic [1:0]          active_phase_q, active_phase_d;
  logic [N_PHASES-1:0] pending_q, pending_d;
  logic                blink_q, blink_d;

  logic [TIMER_W-1:0]  timer;
  logic                cd_done, cd_load, cd_abort, timer_clear;
  logic [N_PHASES-1:0] active_onehot;
  logic                early_start, normal_start;
  lamp_vec_t           lamp;

  assign active_onehot = N_PHASES'(1) << active_phase_q;

  phase_timer #(
    .CD_LEN(T_COUNTDOWN)
  ) u_phase_timer (
    .clk_1Hz        (clk_1Hz),
    .rst_n          (rst_n),
    .timer_clear    (timer_clear),
    .cd_load        (cd_load),
    .cd_abort       (cd_abort),
    .timer          (timer),
    .countdown      (countdown),
    .countdown_valid(countdown_valid),
    .cd_done        (cd_done)
  );

  // Next state and phase advance; enable low or a bad encoding drops to IDLE.
  always_comb begin
    state_d        = state_q;
    active_phase_d = active_phase_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (timer == TIMER_W'(T_IDLE - 1)) begin
            state_d        = ALL_RED;
            active_phase_d = 2'd0;
          end
        end
        ALL_RED: begin
          if (timer == TIMER_W'(T_ALL_RED - 1)) state_d = RED_YELLOW;
        end
        RED_YELLOW: begin
          if (timer == TIMER_W'(T_RED_YELLOW - 1)) state_d = GREEN;
        end
        GREEN: begin
          if (cd_done) state_d = GREEN_BLINK;
        end
        GREEN_BLINK: begin
          if (timer == TIMER_W'(T_GREEN_BLINK - 1)) state_d = YELLOW;
        end
        YELLOW: begin
          if (timer == TIMER_W'(T_YELLOW - 1)) begin
            state_d        = ALL_RED;
            active_phase_d = (active_phase_q == 2'(N_PHASES - 1)) ? 2'd0 : active_phase_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Green always ends through the countdown; a waiting crossing just starts it early.
  always_comb begin
    early_start  = (|(pending_q & ~active_onehot)) && (timer >= TIMER_W'(T_MIN_GREEN));
    normal_start = (timer == TIMER_W'(T_GREEN - T_COUNTDOWN - 1));
    timer_clear  = !enable || (state_d != state_q);
    cd_abort     = (state_d != GREEN);
    cd_load      = (state_q == GREEN) && (state_d == GREEN) && !countdown_valid &&
                   (early_start || normal_start);
  end

  // Pedestrian requests latch until their phase turns green; a new request beats the clear.
  always_comb begin
    pending_d = pending_q;
    if (!enable) begin
      pending_d = '0;
    end else begin
      if ((state_q == RED_YELLOW) && (state_d == GREEN)) pending_d = pending_d & ~active_onehot;
      pending_d = pending_d | ped_req;
    end
  end

  // Idle blink starts dark on entry to IDLE and toggles each cycle spent there.
  always_comb begin
    blink_d = ((state_q == IDLE) && (state_d == IDLE)) ? ~blink_q : 1'b0;
  end

  // Controller state registers.
  always_ff @(posedge clk_1Hz) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      active_phase_q <= 2'd0;
      pending_q      <= '0;
      blink_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_phase_q <= active_phase_d;
      pending_q      <= pending_d;
      blink_q        <= blink_d;
    end
  end

  // Lamps decoded purely from registered state, phase by phase.
  always_comb begin
    red       = '0;
    yellow    = '0;
    green     = '0;
    ped_red   = '0;
    ped_green = '0;
    lamp      = '0;
    for (int i = 0; i < N_PHASES; i++) begin
      lamp         = decode_lamps(state_q, active_onehot[i], timer[0], blink_q);
      red[i]       = lamp.red;
      yellow[i]    = lamp.yellow;
      green[i]     = lamp.green;
      ped_red[i]   = lamp.ped_red;
      ped_green[i] = lamp.ped_green;
    end
  end

  assign active_phase = active_phase_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Directed bench: a default 2-phase controller and a 3-phase controller.
module tb_intersection_controller;

  localparam int S_IDLE = 0, S_AR = 1, S_RY = 2, S_G = 3, S_GB = 4, S_Y = 5;
  localparam int T_CD = 9;

  logic       clk_1Hz = 1'b0;
  logic       rst_n, enable;
  logic [1:0] ped_req;
  logic [1:0] red2, yellow2, green2, ped_red2, ped_green2, ap2, unused_pad;
  logic [3:0] cd2;
  logic       cdv2;
  logic       rst3_n, enable3;
  logic [2:0] ped_req3;
  logic [2:0] red3, yellow3, green3, ped_red3, ped_green3;
  logic [1:0] ap3;
  logic [3:0] cd3;
  logic       cdv3;

  logic       use_dut3;
  logic [3:0] obs_red, obs_yellow, obs_green, obs_ped_red, obs_ped_green, obs_cd;
  logic [1:0] obs_ap;
  logic       obs_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk_1Hz = ~clk_1Hz;

  intersection_controller dut (
    .clk_1Hz(clk_1Hz), .rst_n(rst_n), .enable(enable), .ped_req(ped_req),
    .red(red2), .yellow(yellow2), .green(green2), .ped_red(ped_red2), .ped_green(ped_green2),
    .active_phase(ap2), .countdown(cd2), .countdown_valid(cdv2)
  );

  intersection_controller #(.N_PHASES(3)) dut3 (
    .clk_1Hz(clk_1Hz), .rst_n(rst3_n), .enable(enable3), .ped_req(ped_req3),
    .red(red3), .yellow(yellow3), .green(green3), .ped_red(ped_red3), .ped_green(ped_green3),
    .active_phase(ap3), .countdown(cd3), .countdown_valid(cdv3)
  );

  assign unused_pad = 2'b00;

  // Observe whichever controller is currently under test, zero-padded to 4 phases.
  always_comb begin
    if (use_dut3) begin
      obs_red = {1'b0, red3}; obs_yellow = {1'b0, yellow3}; obs_green = {1'b0, green3};
      obs_ped_red = {1'b0, ped_red3}; obs_ped_green = {1'b0, ped_green3};
      obs_ap = ap3; obs_cd = cd3; obs_valid = cdv3;
    end else begin
      obs_red = {unused_pad, red2}; obs_yellow = {unused_pad, yellow2};
      obs_green = {unused_pad, green2}; obs_ped_red = {unused_pad, ped_red2};
      obs_ped_green = {unused_pad, ped_green2};
      obs_ap = ap2; obs_cd = cd2; obs_valid = cdv2;
    end
  end

  task automatic tick();
    @(posedge clk_1Hz);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] p);
    if (use_dut3) begin
      rst3_n = r; enable3 = e; ped_req3 = p;
    end else begin
      rst_n = r; enable = e; ped_req = p[1:0];
    end
  endtask

  task automatic setPed(input logic [2:0] p);
    if (use_dut3) ped_req3 = p;
    else ped_req = p[1:0];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Expected {red,yellow,green,ped_red,ped_green}, 4 bits each.
  function automatic logic [19:0] expLamps(input int st, input int ap, input int tmr, input int nph);
    logic [3:0] mask, act, r, y, g, pr, pg;
    mask = 4'((1 << nph) - 1);
    act  = 4'(1 << ap);
    r = '0; y = '0; g = '0; pr = '0; pg = '0;
    case (st)
      S_IDLE: y = (tmr % 2 == 1) ? mask : 4'd0;
      S_AR:   begin r = mask; pr = mask; end
      S_RY:   begin r = mask; y = act; pr = mask; end
      S_G:    begin r = mask & ~act; g = act; pr = mask & ~act; pg = act; end
      S_GB:   begin r = mask & ~act; g = (tmr % 2 == 0) ? act : 4'd0; pr = mask; end
      S_Y:    begin r = mask & ~act; y = act; pr = mask; end
      default: ;
    endcase
    return {r, y, g, pr, pg};
  endfunction

  task automatic runState(input string tag, input int st, input int ap, input int len,
                          input int cd_start, input int ped_at, input logic [2:0] ped_mask,
                          input int nph);
    logic       exp_valid;
    logic [3:0] exp_cd, mask;
    int         multi_go;
    mask = 4'((1 << nph) - 1);
    multi_go = 0;
    for (int t = 0; t < len; t++) begin
      checkOutput($sformatf("%s_lamps_t%0d", tag, t),
                  32'({obs_red, obs_yellow, obs_green, obs_ped_red, obs_ped_green}),
                  32'(expLamps(st, ap, t, nph)));
      exp_valid = (st == S_G) && (cd_start >= 0) && (t >= cd_start);
      exp_cd    = exp_valid ? 4'(T_CD - 1 - (t - cd_start)) : 4'd0;
      checkOutput($sformatf("%s_cd_t%0d", tag, t), 32'({obs_valid, obs_cd}), 32'({exp_valid, exp_cd}));
      checkOutput($sformatf("%s_ap_t%0d", tag, t), 32'(obs_ap), 32'(ap));
      if (st != S_IDLE && $countones(~obs_red & mask) > 1) multi_go++;
      if (t == ped_at) begin
        setPed(ped_mask);
        tick();
        setPed(3'b000);
      end else begin
        tick();
      end
    end
    checkOutput($sformatf("%s_one_go", tag), 32'(multi_go), 32'd0);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_lamps"},
                32'({obs_red, obs_yellow, obs_green, obs_ped_red, obs_ped_green}), 32'd0);
    checkOutput({tag, "_cd"}, 32'({obs_valid, obs_cd}), 32'd0);
    checkOutput({tag, "_ap"}, 32'(obs_ap), 32'd0);
  endtask

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence.
  initial begin
    use_dut3 = 1'b0;
    rst_n = 1'b0; enable = 1'b1; ped_req = 2'b11;
    rst3_n = 1'b0; enable3 = 1'b0; ped_req3 = 3'b000;
    tick(); tick();
    checkReset("rst");
    applyStimulus(1'b1, 1'b1, 3'b000);

    runState("p0_idle", S_IDLE, 0, 6, -1, -1, 3'b000, 2);
    runState("p0_ar", S_AR, 0, 2, -1, -1, 3'b000, 2);
    runState("p0_ry", S_RY, 0, 3, -1, -1, 3'b000, 2);
    runState("p0_g", S_G, 0, 20, 11, -1, 3'b000, 2);
    runState("p0_gb", S_GB, 0, 6, -1, -1, 3'b000, 2);
    runState("p0_y", S_Y, 0, 3, -1, -1, 3'b000, 2);
    runState("p1_ar", S_AR, 1, 2, -1, -1, 3'b000, 2);
    runState("p1_ry", S_RY, 1, 3, -1, -1, 3'b000, 2);
    runState("p1_g", S_G, 1, 20, 11, -1, 3'b000, 2);
    runState("p1_gb", S_GB, 1, 6, -1, -1, 3'b000, 2);
    runState("p1_y", S_Y, 1, 3, -1, -1, 3'b000, 2);

    runState("ped_ar", S_AR, 0, 2, -1, -1, 3'b000, 2);
    runState("ped_ry", S_RY, 0, 3, -1, -1, 3'b000, 2);
    runState("ped_g", S_G, 0, 15, 6, 2, 3'b010, 2);
    runState("ped_gb", S_GB, 0, 3, -1, -1, 3'b000, 2);

    applyStimulus(1'b1, 1'b0, 3'b000);
    tick();
    runState("drop_idle", S_IDLE, 0, 4, -1, -1, 3'b000, 2);
    applyStimulus(1'b1, 1'b1, 3'b000);
    runState("re_idle", S_IDLE, 0, 6, -1, -1, 3'b000, 2);
    runState("re_ar", S_AR, 0, 2, -1, -1, 3'b000, 2);
    runState("re_ry", S_RY, 0, 3, -1, -1, 3'b000, 2);
    runState("re_g", S_G, 0, 14, 11, -1, 3'b000, 2);

    applyStimulus(1'b0, 1'b1, 3'b011);
    tick();
    checkReset("midcd_rst");
    applyStimulus(1'b1, 1'b1, 3'b000);
    runState("post_idle", S_IDLE, 0, 6, -1, -1, 3'b000, 2);
    runState("post_ar", S_AR, 0, 2, -1, -1, 3'b000, 2);
    runState("post_ry", S_RY, 0, 3, -1, -1, 3'b000, 2);
    applyStimulus(1'b1, 1'b0, 3'b000);

    use_dut3 = 1'b1;
    #1;
    checkReset("n3_rst");
    applyStimulus(1'b1, 1'b1, 3'b000);
    runState("n3_idle", S_IDLE, 0, 6, -1, -1, 3'b000, 3);
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 3; p++) begin
        runState($sformatf("n3_r%0d_p%0d_ar", r, p), S_AR, p, 2, -1, -1, 3'b000, 3);
        runState($sformatf("n3_r%0d_p%0d_ry", r, p), S_RY, p, 3, -1, -1, 3'b000, 3);
        runState($sformatf("n3_r%0d_p%0d_g", r, p), S_G, p, 20, 11, -1, 3'b000, 3);
        runState($sformatf("n3_r%0d_p%0d_gb", r, p), S_GB, p, 6, -1, -1, 3'b000, 3);
        runState($sformatf("n3_r%0d_p%0d_y", r, p), S_Y, p, 3, -1, -1, 3'b000, 3);
      end
    end
    runState("n3_wrap_ar", S_AR, 0, 2, -1, -1, 3'b000, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
